// File: rtl/row_seq_mux_pkg.sv
// Shared definitions for the row sequencer: default geometry and scan FSM encoding.
package row_seq_mux_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_NUM_ROWS   = 10;
    localparam int unsigned DEFAULT_SEL_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/row_seq_mux_select.sv
// Pure combinational row lookup: index -> row word, with an in-range flag.
module row_select_comb
    import row_seq_mux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_ROWS   = DEFAULT_NUM_ROWS,
    parameter int unsigned SEL_WIDTH  = DEFAULT_SEL_WIDTH
) (
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] rows_in,
    input  logic [SEL_WIDTH-1:0]           idx,
    output logic [DATA_WIDTH-1:0]          row_c,
    output logic                           hit_c
);

    // Out-of-range indices yield zero with hit_c low, never a stale word.
    always_comb begin
        row_c = '0;
        hit_c = 1'b0;
        for (int k = 0; k < int'(NUM_ROWS); k++) begin
            if (idx == SEL_WIDTH'(k)) begin
                row_c = rows_in[k*DATA_WIDTH +: DATA_WIDTH];
                hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_seq_mux.sv
// Registered row multiplexer with manual select and a handshaked auto-scan over all rows.
module row_seq_mux
    import row_seq_mux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_ROWS   = DEFAULT_NUM_ROWS,
    parameter int unsigned SEL_WIDTH  = DEFAULT_SEL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] rows_in,
    input  logic [SEL_WIDTH-1:0]           sel,
    input  logic                           ena,
    input  logic                           mode,
    input  logic                           start,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out,
    output logic                           out_valid,
    output logic [SEL_WIDTH-1:0]           out_idx,
    output logic                           busy,
    output logic                           done
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_ROWS - 1);

    scan_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_WIDTH-1:0]  out_idx_q, out_idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [SEL_WIDTH-1:0]  lookup_idx_c;
    logic [DATA_WIDTH-1:0] row_c;
    logic                  hit_c;
    logic                  free_c;

    // During a scan out_idx_q doubles as the scan index; the lookup fetches the next row.
    always_comb begin
        lookup_idx_c = sel;
        if (state_q == ST_SCAN) begin
            lookup_idx_c = out_idx_q + SEL_WIDTH'(1);
        end else if (mode) begin
            lookup_idx_c = '0;
        end
    end

    row_select_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_ROWS   (NUM_ROWS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_select (
        .rows_in (rows_in),
        .idx     (lookup_idx_c),
        .row_c   (row_c),
        .hit_c   (hit_c)
    );

    assign free_c = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;

        if (!ena) begin
            state_d     = ST_IDLE;
            out_d       = '0;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (free_c) begin
                        if (!mode) begin
                            out_d       = row_c;
                            out_valid_d = hit_c;
                            out_idx_d   = hit_c ? sel : '0;
                        end else if (start) begin
                            state_d     = ST_SCAN;
                            out_d       = row_c;
                            out_valid_d = 1'b1;
                            out_idx_d   = '0;
                        end else begin
                            out_d       = '0;
                            out_valid_d = 1'b0;
                            out_idx_d   = '0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (out_valid_q && out_ready) begin
                        if (out_idx_q == LAST_IDX) begin
                            state_d     = ST_DONE;
                            out_d       = '0;
                            out_valid_d = 1'b0;
                            out_idx_d   = '0;
                        end else begin
                            out_d       = row_c;
                            out_valid_d = 1'b1;
                            out_idx_d   = lookup_idx_c;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    out_idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_SCAN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_row_seq_mux.sv
// Self-checking bench for row_seq_mux: manual select, range checks, scans with stall/abort/reset.
module tb_row_seq_mux;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 10;
    localparam int unsigned SW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] idx;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*DW-1:0] rows_in;
    logic [SW-1:0]    sel;
    logic             ena;
    logic             mode;
    logic             start;
    logic             out_ready;
    logic [DW-1:0]    out;
    logic             out_valid;
    logic [SW-1:0]    out_idx;
    logic             busy;
    logic             done;

    int    checks   = 0;
    int    failures = 0;
    logic  mon_en   = 1'b0;
    beat_t sb_q[$];

    always #5 clk = ~clk;

    row_seq_mux #(
        .DATA_WIDTH (DW),
        .NUM_ROWS   (NR),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rows_in   (rows_in),
        .sel       (sel),
        .ena       (ena),
        .mode      (mode),
        .start     (start),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+2, so at the negedge out_ready already reflects the coming edge.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (mon_en && !rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else if (out_ready) begin
                e = sb_q.pop_front();
                check("beat_data", out, e.data);
                check("beat_idx", 32'(out_idx), 32'(e.idx));
                check("beat_busy", 32'(busy), 32'd1);
                check("beat_done", 32'(done), 32'd0);
            end else begin
                check("hold_data", out, sb_q[0].data);
                check("hold_idx", 32'(out_idx), 32'(sb_q[0].idx));
            end
        end
    end

    task automatic manual_chk(input logic [SW-1:0] s, input logic [DW-1:0] eo, input logic ev);
        @(posedge clk); #2;
        sel = s;
        @(posedge clk);
        @(negedge clk);
        check("man_out", out, eo);
        check("man_valid", 32'(out_valid), 32'(ev));
        if (ev) check("man_idx", 32'(out_idx), 32'(s));
    endtask

    task automatic run_scan(input string name, input int stall_at, input int abort_at, input int exp_done);
        int    done_cyc;
        int    done_cnt;
        beat_t b;
        done_cyc = 0;
        done_cnt = 0;
        @(posedge clk); #2;
        mode      = 1'b1;
        ena       = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        for (int k = 0; k < int'(NR); k++) begin
            b.data = DW'(32'h1000 + k);
            b.idx  = SW'(k);
            sb_q.push_back(b);
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #2;
            if (c == 1) mon_en = 1'b1;
            start     = (c == 3) || (c == 16);
            mode      = (c < 6);
            out_ready = !(stall_at != 0 && c >= stall_at && c < stall_at + 3);
            ena       = !(abort_at != 0 && c >= abort_at);
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
                mon_en = 1'b0;
            end
            if (abort_at != 0 && c == abort_at + 1) begin
                check({name, "_abort_out"}, out, 32'd0);
                check({name, "_abort_valid"}, 32'(out_valid), 32'd0);
                check({name, "_abort_busy"}, 32'(busy), 32'd0);
            end
        end
        mon_en = 1'b0;
        check({name, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
        check({name, "_done_cnt"}, 32'(done_cnt), (exp_done == 0) ? 32'd0 : 32'd1);
        check({name, "_remaining"}, 32'(sb_q.size()), (abort_at == 0) ? 32'd0 : 32'(int'(NR) - abort_at));
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        sb_q.delete();
        ena   = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        int rst_done;
        rst       = 1'b1;
        ena       = 1'b0;
        mode      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        sel       = '0;
        for (int k = 0; k < int'(NR); k++) rows_in[k*DW +: DW] = DW'(32'h1000 + k);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", out, 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        ena = 1'b1;

        manual_chk(SW'(3), 32'h1003, 1'b1);
        manual_chk(SW'(0), 32'h1000, 1'b1);
        manual_chk(SW'(9), 32'h1009, 1'b1);
        manual_chk(SW'(5), 32'h1005, 1'b1);
        manual_chk(SW'(12), 32'h0, 1'b0);
        manual_chk(SW'(10), 32'h0, 1'b0);
        manual_chk(SW'(7), 32'h1007, 1'b1);

        @(posedge clk); #2;
        ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ena0_out", out, 32'd0);
        check("ena0_valid", 32'(out_valid), 32'd0);
        check("ena0_idx", 32'(out_idx), 32'd0);
        ena = 1'b1;

        run_scan("scan", 0, 0, 11);
        run_scan("bp", 5, 0, 14);
        run_scan("abort", 0, 7, 0);

        @(posedge clk); #2;
        mode      = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_out", out, 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_idx", 32'(out_idx), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        rst_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) rst_done++;
        end
        check("arst_no_done", 32'(rst_done), 32'd0);
        rst = 1'b0;

        run_scan("post_rst", 0, 0, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
